// File: rtl/alu_sequencer.sv
// ALU execute-interface initiator: takes one instruction at a time, drives the ALU with
// register-file operands, waits out the ALU latency, then writes the result back.
module alu_sequencer #(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [7:0]  alu_imm,
    output logic [2:0]  alu_control,
    output logic        alu_execute,
    input  logic [7:0]  alu_out,
    input  logic        alu_zf,
    input  logic        alu_cf,
    output logic        done,
    output logic        zf,
    output logic        cf,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned REG_W    = 2;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned NUM_REGS = 4;

    localparam logic [OP_W-1:0] OP_NOP = 3'b101;
    localparam logic [OP_W-1:0] OP_SUB = 3'b111;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs;
        logic              imm_sel;
        logic [DATA_W-1:0] imm;
    } instr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    instr_t             instr_f;
    logic [OP_W-1:0]    op_q;
    logic [REG_W-1:0]   rd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic               accept_c;
    logic               wb_c;
    logic               write_c;
    logic               flag_upd_c;

    assign instr_f = instr_t'(instr);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (cnt_q == CNT_W'(1)) state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake and writeback strobes decoded from state
    always_comb begin
        instr_ready = 1'b0;
        accept_c    = 1'b0;
        wb_c        = 1'b0;
        write_c     = 1'b0;
        flag_upd_c  = 1'b0;
        instr_ready = (state_q == S_IDLE);
        accept_c    = instr_valid && (state_q == S_IDLE);
        wb_c        = (state_q == S_WB);
        write_c     = wb_c && (op_q != OP_NOP);
        flag_upd_c  = wb_c && (op_q == OP_SUB);
    end

    // Operands are captured at accept so they are presented throughout the ISSUE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            rd_q        <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_imm     <= '0;
            alu_control <= '0;
            alu_execute <= 1'b0;
        end else begin
            alu_execute <= accept_c;
            if (accept_c) begin
                op_q        <= instr_f.op;
                rd_q        <= instr_f.rd;
                alu_a       <= regs_q[instr_f.rd];
                alu_b       <= instr_f.imm_sel ? instr_f.imm : regs_q[instr_f.rs];
                alu_imm     <= instr_f.imm;
                alu_control <= instr_f.op;
            end
        end
    end

    // Latency counter: loaded while issuing, counts down through WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            cnt_q <= CNT_W'(ALU_LATENCY);
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_c) begin
            regs_q[rd_q] <= alu_out;
        end
    end

    // Flags follow the ALU only on subtract; done marks the cycle after writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf   <= 1'b0;
            cf   <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= wb_c;
            if (flag_upd_c) begin
                zf <= alu_zf;
                cf <= alu_cf;
            end
        end
    end

    assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (ALU latency 1 and 3), each with a delayed ALU
// model and a transaction-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fails = 0;
    bit          fin [2];

    task automatic chk(input string name, input int lat, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s (ALU_LATENCY=%0d): got 0x%02h, expected 0x%02h at %0t", name, lat, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                                        input logic isel, input logic [7:0] imm);
        return {op, rd, rs, isel, imm};
    endfunction

    // Result of each opcode; bit 8 is carry (add) or borrow (sub)
    function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] imm);
        logic [8:0] r;
        case (op)
            3'b000:  r = {1'b0, ~(a & b)};
            3'b001:  r = {1'b0, a & b};
            3'b010:  r = {1'b0, a ^ b};
            3'b011:  r = {1'b0, a >> imm};
            3'b100:  r = {1'b0, b};
            3'b110:  r = {1'b0, a} + {1'b0, b};
            3'b111:  r = {1'b0, a} - {1'b0, b};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        rst;
        logic        instr_valid;
        logic        instr_ready;
        logic [15:0] instr;
        logic [7:0]  alu_a;
        logic [7:0]  alu_b;
        logic [7:0]  alu_imm;
        logic [2:0]  alu_control;
        logic        alu_execute;
        logic [7:0]  alu_out;
        logic        alu_zf;
        logic        alu_cf;
        logic        done;
        logic        zf;
        logic        cf;
        logic [1:0]  dbg_sel;
        logic [7:0]  dbg_data;

        alu_sequencer #(.ALU_LATENCY(LAT)) dut (
            .clk(clk), .rst(rst),
            .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
            .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_control(alu_control),
            .alu_execute(alu_execute), .alu_out(alu_out), .alu_zf(alu_zf), .alu_cf(alu_cf),
            .done(done), .zf(zf), .cf(cf), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
        );

        // ALU: result is valid for exactly one cycle, LAT edges after the execute edge
        logic [8:0] a_res = '0;
        int         a_cnt = 0;
        logic       a_vld = 1'b0;
        always @(posedge clk) begin
            a_vld <= 1'b0;
            if (alu_execute) begin
                a_res <= alu_fn(alu_control, alu_a, alu_b, alu_imm);
                a_cnt <= LAT;
            end else if (a_cnt != 0) begin
                a_cnt <= a_cnt - 1;
                if (a_cnt == 1) a_vld <= 1'b1;
            end
        end
        assign alu_out = a_vld ? a_res[7:0] : (a_res[7:0] ^ 8'h5A);
        assign alu_zf  = a_vld ? (a_res[7:0] == 8'h00) : (a_res[7:0] != 8'h00);
        assign alu_cf  = a_vld ? a_res[8] : ~a_res[8];

        // Reference model: architectural state plus cycles elapsed since the last accept
        logic [7:0]  m_reg [4];
        logic        m_zf, m_cf, m_done, m_busy;
        int          m_since;
        logic [2:0]  m_op;
        logic [1:0]  m_rd;
        logic [7:0]  m_a, m_b, m_imm;
        logic [15:0] dq [$];
        bit          rst_in_wait;

        task automatic model_reset();
            for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
            m_zf = 0; m_cf = 0; m_done = 0; m_busy = 0; m_since = 0;
            m_op = '0; m_rd = '0; m_a = '0; m_b = '0; m_imm = '0;
        endtask

        task automatic check_cycle();
            dbg_sel = 2'($urandom_range(0, 3));
            #1;
            chk("instr_ready", LAT, instr_ready, !m_busy);
            chk("alu_execute", LAT, alu_execute, m_busy && (m_since == 1));
            chk("done", LAT, done, m_done);
            chk("zf", LAT, zf, m_zf);
            chk("cf", LAT, cf, m_cf);
            chk("alu_a", LAT, alu_a, m_a);
            chk("alu_b", LAT, alu_b, m_b);
            chk("alu_imm", LAT, alu_imm, m_imm);
            chk("alu_control", LAT, alu_control, m_op);
            chk("dbg_data", LAT, dbg_data, m_reg[dbg_sel]);
        endtask

        task automatic step(input bit rnd);
            logic [8:0] res;
            @(negedge clk);
            check_cycle();
            // Drive inputs for the coming edge
            rst = (!rnd && rst_in_wait && m_busy && m_since == 2) ||
                  (rnd && m_busy && $urandom_range(0, 49) == 0);
            if (rst) rst_in_wait = 0;
            if (rst) begin
                instr_valid = 0;
                instr = 16'($urandom);
            end else if (m_busy) begin
                instr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                instr = 16'($urandom);
            end else if (dq.size() != 0) begin
                instr_valid = 1;
                instr = dq[0];
            end else if (rnd) begin
                instr_valid = ($urandom_range(0, 3) != 0);
                instr = 16'($urandom);
            end else begin
                instr_valid = 0;
                instr = 16'($urandom);
            end
            // Predict the effect of the coming edge
            if (rst) begin
                model_reset();
            end else begin
                m_done = 0;
                if (!m_busy) begin
                    if (instr_valid) begin
                        if (dq.size() != 0) void'(dq.pop_front());
                        m_busy  = 1;
                        m_since = 1;
                        m_op    = instr[15:13];
                        m_rd    = instr[12:11];
                        m_a     = m_reg[m_rd];
                        m_b     = instr[8] ? instr[7:0] : m_reg[instr[10:9]];
                        m_imm   = instr[7:0];
                    end
                end else begin
                    m_since++;
                    if (m_since == 3 + LAT) begin
                        res = alu_fn(m_op, m_a, m_b, m_imm);
                        if (m_op != 3'b101) m_reg[m_rd] = res[7:0];
                        if (m_op == 3'b111) begin
                            m_zf = (res[7:0] == 8'h00);
                            m_cf = res[8];
                        end
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end
        endtask

        task automatic drain();
            int guard = 0;
            do begin
                step(0);
                guard++;
            end while ((m_busy || dq.size() != 0) && guard < 200);
            step(0);
        endtask

        task automatic lit(input string name, input int r, input logic [7:0] exp);
            dbg_sel = 2'(r);
            #1;
            chk(name, LAT, dbg_data, exp);
            chk({name, " (model)"}, LAT, m_reg[r], exp);
        endtask

        task automatic litf(input string name, input logic ez, input logic ec);
            chk({name, " zf"}, LAT, zf, ez);
            chk({name, " cf"}, LAT, cf, ec);
            chk({name, " model zf"}, LAT, m_zf, ez);
            chk({name, " model cf"}, LAT, m_cf, ec);
        endtask

        initial begin
            rst = 1; instr_valid = 0; instr = '0; dbg_sel = '0; rst_in_wait = 0;
            model_reset();

            dq.push_back(enc(3'b100, 2'd1, 2'd0, 1'b1, 8'h05));
            dq.push_back(enc(3'b100, 2'd2, 2'd0, 1'b1, 8'h03));
            drain();
            lit("load r1", 1, 8'h05);
            lit("load r2", 2, 8'h03);

            dq.push_back(enc(3'b110, 2'd1, 2'd2, 1'b0, 8'h00));
            drain();
            lit("add r1", 1, 8'h08);

            dq.push_back(enc(3'b111, 2'd2, 2'd2, 1'b0, 8'h00));
            drain();
            lit("sub r2-r2", 2, 8'h00);
            litf("sub zero", 1'b1, 1'b0);

            dq.push_back(enc(3'b100, 2'd3, 2'd0, 1'b1, 8'h01));
            dq.push_back(enc(3'b111, 2'd3, 2'd0, 1'b1, 8'h02));
            drain();
            lit("sub imm r3", 3, 8'hFF);
            litf("sub borrow", 1'b0, 1'b1);

            dq.push_back(enc(3'b010, 2'd0, 2'd1, 1'b0, 8'h00));
            drain();
            lit("xor r0", 0, 8'h08);
            litf("xor keeps", 1'b0, 1'b1);

            dq.push_back(enc(3'b100, 2'd1, 2'd0, 1'b1, 8'h80));
            dq.push_back(enc(3'b011, 2'd1, 2'd0, 1'b0, 8'h03));
            drain();
            lit("shr r1", 1, 8'h10);

            dq.push_back(enc(3'b100, 2'd2, 2'd0, 1'b1, 8'hFF));
            dq.push_back(enc(3'b000, 2'd2, 2'd2, 1'b0, 8'h00));
            drain();
            lit("nand r2", 2, 8'h00);

            dq.push_back(enc(3'b101, 2'd3, 2'd1, 1'b1, 8'h55));
            drain();
            lit("nop r3", 3, 8'hFF);

            rst_in_wait = 1;
            dq.push_back(enc(3'b110, 2'd1, 2'd1, 1'b0, 8'h00));
            drain();
            lit("reset r0", 0, 8'h00);
            lit("reset r1", 1, 8'h00);
            lit("reset r2", 2, 8'h00);
            lit("reset r3", 3, 8'h00);

            for (int i = 0; i < 400; i++) step(1);
            fin[g] = 1;
        end
    end

    initial begin
        for (int i = 0; i < 40000 && !(fin[0] && fin[1]); i++) @(posedge clk);
        if (!(fin[0] && fin[1])) begin
            n_fails++;
            $display("FAIL timeout: instances finished %0d/%0d, required 1/1", fin[0], fin[1]);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
